// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg
// Shared constants and types for the SRAM bank write-side arbiter and for
// the schedulers that reuse its round-robin picker.
// Optional feature macro used by the arbiter: ARB_WATCHDOG_EN.
package sram_port_arbiter_pkg;

  localparam int PORT_NUM = 16;
  localparam int DATA_W   = 16;
  localparam int LEN_W    = 9;
  localparam int TIMEOUT  = 63;

  typedef logic [3:0]       port_idx_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef logic [10:0]      space_t;

  localparam space_t CAPACITY = 11'd2047;

  typedef enum logic [0:0] {IDLE = 1'b0, BOUND = 1'b1} arb_state_e;

  // A zero-length request still occupies one cell in the bank.
  function automatic len_t eff_len(input len_t len);
    return (len == '0) ? len_t'(1) : len;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if
// Bundle between the 16 port write frontends and one bank arbiter.
//   req       per-port bind request (level, held until granted)
//   req_len   packed per-port packet length in cells
//   xfer_vld  per-port cell valid
//   xfer_data packed per-port cell data
//   xfer_eop  per-port last-cell flag, qualified by xfer_vld
//   grant     one-hot owner, zero when idle
//   owner     binary owner index, zero when idle
//   busy      bank currently owned
// master: frontend side, slave: arbiter side.
interface sram_port_arbiter_if;
  import sram_port_arbiter_pkg::*;

  logic [PORT_NUM-1:0]        req;
  logic [PORT_NUM*LEN_W-1:0]  req_len;
  logic [PORT_NUM-1:0]        xfer_vld;
  logic [PORT_NUM*DATA_W-1:0] xfer_data;
  logic [PORT_NUM-1:0]        xfer_eop;
  logic [PORT_NUM-1:0]        grant;
  port_idx_t                  owner;
  logic                       busy;

  modport master (
    output req, req_len, xfer_vld, xfer_data, xfer_eop,
    input  grant, owner, busy
  );

  modport slave (
    input  req, req_len, xfer_vld, xfer_data, xfer_eop,
    output grant, owner, busy
  );

endinterface

// File: rtl/sram_port_arbiter_rr_picker_16.sv
// rr_picker_16
// Combinational round-robin search: returns the first set bit of req_vec
// found scanning upward from ptr, wrapping 15 -> 0.
//   req_vec  in  16  candidate vector
//   ptr      in  4   search start position
//   vld      out 1   some candidate found
//   idx      out 4   index of the chosen candidate (0 when none)
module rr_picker_16
  import sram_port_arbiter_pkg::*;
(
  input  logic [15:0] req_vec,
  input  port_idx_t   ptr,
  output logic        vld,
  output port_idx_t   idx
);

  port_idx_t cand;

  // Scan offsets from far to near so the nearest hit to ptr is the last
  // assignment and therefore wins.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int i = 15; i >= 0; i--) begin
      cand = ptr + 4'(i);
      if (req_vec[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter
// Binds one SRAM bank to a single write port for a whole packet with
// round-robin fairness, reserves the packet's cells against free space,
// forwards the owner's cells to the SRAM write port and credits cells back
// as the read side frees them.
//   clk, rst_n    clock and asynchronous active-low reset
//   port_if       frontend bundle (slave modport)
//   free_vld      read side released one cell this cycle
//   sram_wr_en    registered SRAM write strobe
//   sram_wr_data  registered SRAM write data
//   free_space    unreserved cells in the bank
//   abort         one-cycle pulse when the watchdog reclaims the bank
// Optional: define ARB_WATCHDOG_EN to reclaim the bank from an owner that
// stalls for TIMEOUT cycles; otherwise abort is tied low.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  sram_port_arbiter_if.slave  port_if,
  input  logic                free_vld,
  output logic                sram_wr_en,
  output logic [DATA_W-1:0]   sram_wr_data,
  output space_t              free_space,
  output logic                abort
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BOUND = 1'b1;

  logic [0:0]          state;
  port_idx_t           rr_ptr;
  port_idx_t           owner_q;
  logic [PORT_NUM-1:0] grant_q;
  logic                busy_q;
  logic [PORT_NUM-1:0] elig;
  logic                pick_vld;
  port_idx_t           pick_idx;
  len_t                win_len;
  logic                take_grant;
  logic                cell_vld;
  logic                end_pkt;
  logic                wd_fire;
  logic [11:0]         fs_sum;

  assign port_if.grant = grant_q;
  assign port_if.owner = owner_q;
  assign port_if.busy  = busy_q;

  // A requester is eligible only if its packet fits in the unreserved space,
  // so ports that do not fit are skipped rather than blocking the others.
  always_comb begin
    elig = '0;
    for (int i = 0; i < PORT_NUM; i++) begin
      elig[i] = port_if.req[i] &&
                ({2'b00, eff_len(port_if.req_len[i*LEN_W +: LEN_W])} <= free_space);
    end
  end

  rr_picker_16 u_picker (
    .req_vec (elig),
    .ptr     (rr_ptr),
    .vld     (pick_vld),
    .idx     (pick_idx)
  );

  assign win_len    = eff_len(port_if.req_len[pick_idx*LEN_W +: LEN_W]);
  assign take_grant = (state == S_IDLE) && pick_vld;
  assign cell_vld   = (state == S_BOUND) && port_if.xfer_vld[owner_q];
  assign end_pkt    = cell_vld && port_if.xfer_eop[owner_q];

`ifdef ARB_WATCHDOG_EN
  localparam logic [5:0] IDLE_LIMIT = 6'(TIMEOUT - 1);

  logic [5:0] idle_cnt;
  len_t       wr_cnt;
  len_t       len_q;
  len_t       credit;

  assign wd_fire = (state == S_BOUND) && !cell_vld && (idle_cnt == IDLE_LIMIT);
  assign credit  = (wd_fire && (len_q > wr_cnt)) ? (len_q - wr_cnt) : '0;

  // Watchdog bookkeeping: stall cycles since the owner's last cell, and how
  // many of the reserved cells were actually written, so an abort can hand
  // back exactly the unused part of the reservation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
      wr_cnt   <= '0;
      len_q    <= '0;
      abort    <= 1'b0;
    end else begin
      abort <= wd_fire;
      if (take_grant) begin
        idle_cnt <= '0;
        wr_cnt   <= '0;
        len_q    <= win_len;
      end else if (state == S_BOUND) begin
        if (cell_vld) begin
          idle_cnt <= '0;
          if (wr_cnt != '1) wr_cnt <= wr_cnt + len_t'(1);
        end else if (wd_fire) begin
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 6'd1;
        end
      end
    end
  end
`else
  assign wd_fire = 1'b0;
  assign abort   = 1'b0;
`endif

  // Next free space: release credit (ignored when already full), minus the
  // new reservation, plus any watchdog refund, clamped at capacity.
  always_comb begin
    fs_sum = {1'b0, free_space};
    if (free_vld && (free_space != CAPACITY)) fs_sum = fs_sum + 12'd1;
    if (take_grant) fs_sum = fs_sum - {3'b000, win_len};
`ifdef ARB_WATCHDOG_EN
    fs_sum = fs_sum + {3'b000, credit};
`endif
    if (fs_sum > {1'b0, CAPACITY}) fs_sum = {1'b0, CAPACITY};
  end

  // Bind/release FSM plus the registered SRAM write path. The pointer moves
  // past the departing owner so every port gets a turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      busy_q       <= 1'b0;
      free_space   <= CAPACITY;
      sram_wr_en   <= 1'b0;
      sram_wr_data <= '0;
    end else begin
      free_space <= fs_sum[10:0];
      sram_wr_en <= 1'b0;
      if (state == S_IDLE) begin
        if (pick_vld) begin
          state   <= S_BOUND;
          owner_q <= pick_idx;
          grant_q <= {{(PORT_NUM-1){1'b0}}, 1'b1} << pick_idx;
          busy_q  <= 1'b1;
        end
      end else begin
        if (cell_vld) begin
          sram_wr_en   <= 1'b1;
          sram_wr_data <= port_if.xfer_data[owner_q*DATA_W +: DATA_W];
        end
        if (end_pkt || wd_fire) begin
          state   <= S_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
          owner_q <= '0;
          rr_ptr  <= owner_q + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter
// Directed bench for sram_port_arbiter. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge they follow.
// With ARB_WATCHDOG_EN defined an extra watchdog section is exercised.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  logic                clk;
  logic                rst_n;
  logic                free_vld;
  logic                sram_wr_en;
  logic [DATA_W-1:0]   sram_wr_data;
  space_t              free_space;
  logic                abort;
  int                  checks;
  int                  errors;

  sram_port_arbiter_if bus ();

  sram_port_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .port_if      (bus),
    .free_vld     (free_vld),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_data (sram_wr_data),
    .free_space   (free_space),
    .abort        (abort)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run always ends even if sequencing goes wrong
  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // One comparison: count it and report any difference
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one port's request line and length
  task automatic applyStimulus(input int port, input int len, input logic on);
    bus.req[port] = on;
    bus.req_len[port*LEN_W +: LEN_W] = LEN_W'(len);
  endtask

  // Drive one port's cell lane
  task automatic setCell(input int port, input int data, input logic vld, input logic eop);
    bus.xfer_vld[port] = vld;
    bus.xfer_eop[port] = eop;
    bus.xfer_data[port*DATA_W +: DATA_W] = DATA_W'(data);
  endtask

  task automatic clearInputs();
    bus.req       = '0;
    bus.req_len   = '0;
    bus.xfer_vld  = '0;
    bus.xfer_data = '0;
    bus.xfer_eop  = '0;
    free_vld      = 1'b0;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    stepCycles(2);
    rst_n = 1'b1;
    stepCycles(1);
  endtask

  // Request, get granted next edge, send a single eop cell, then one idle cycle
  task automatic bindAndFinish(input int port, input int len, input int data);
    applyStimulus(port, len, 1'b1);
    stepCycles(1);
    checkOutput("fill_grant", 32'(bus.grant), 32'(1) << port);
    applyStimulus(port, len, 1'b0);
    setCell(port, data, 1'b1, 1'b1);
    stepCycles(1);
    setCell(port, 0, 1'b0, 1'b0);
    stepCycles(1);
  endtask

  // Expect the given port to own the bank now, move one eop cell through it
  task automatic servePacket(input int port, input int data);
    checkOutput("rr_grant", 32'(bus.grant), 32'(1) << port);
    checkOutput("rr_owner", 32'(bus.owner), 32'(port));
    setCell(port, data, 1'b1, 1'b1);
    stepCycles(1);
    checkOutput("rr_wr_en", 32'(sram_wr_en), 32'd1);
    checkOutput("rr_wr_data", 32'(sram_wr_data), 32'(data));
    checkOutput("rr_busy_after", 32'(bus.busy), 32'd0);
    setCell(port, 0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clearInputs();
    stepCycles(3);
    rst_n = 1'b1;
    stepCycles(1);

    // Reset state
    checkOutput("rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("rst_owner", 32'(bus.owner), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_wr_en", 32'(sram_wr_en), 32'd0);
    checkOutput("rst_wr_data", 32'(sram_wr_data), 32'd0);
    checkOutput("rst_free", 32'(free_space), 32'd2047);
    checkOutput("rst_abort", 32'(abort), 32'd0);

    // Port 3, 10-cell packet
    applyStimulus(3, 10, 1'b1);
    stepCycles(1);
    checkOutput("p3_grant", 32'(bus.grant), 32'h0008);
    checkOutput("p3_owner", 32'(bus.owner), 32'd3);
    checkOutput("p3_busy", 32'(bus.busy), 32'd1);
    checkOutput("p3_free", 32'(free_space), 32'd2037);
    applyStimulus(3, 10, 1'b0);
    for (int k = 0; k < 10; k++) begin
      setCell(3, 'hA000 + k, 1'b1, (k == 9));
      stepCycles(1);
      checkOutput("p3_wr_en", 32'(sram_wr_en), 32'd1);
      checkOutput("p3_wr_data", 32'(sram_wr_data), 32'hA000 + 32'(k));
    end
    setCell(3, 0, 1'b0, 1'b0);
    checkOutput("p3_busy_end", 32'(bus.busy), 32'd0);
    checkOutput("p3_grant_end", 32'(bus.grant), 32'd0);
    stepCycles(1);
    checkOutput("p3_wr_en_end", 32'(sram_wr_en), 32'd0);
    checkOutput("p3_free_end", 32'(free_space), 32'd2037);

    // Round robin among ports 2, 5, 9 from a fresh pointer
    doReset();
    applyStimulus(2, 1, 1'b1);
    applyStimulus(5, 1, 1'b1);
    applyStimulus(9, 1, 1'b1);
    stepCycles(1);
    servePacket(2, 'h0202);
    stepCycles(1);
    servePacket(5, 'h0505);
    stepCycles(1);
    servePacket(9, 'h0909);
    stepCycles(1);
    servePacket(2, 'h0222);
    bus.req = '0;
    stepCycles(1);
    checkOutput("rr_idle", 32'(bus.busy), 32'd0);
    checkOutput("rr_free", 32'(free_space), 32'd2043);

    // Shrink free space to 5, then a too-long request is skipped
    doReset();
    bindAndFinish(0, 511, 'h1);
    bindAndFinish(0, 511, 'h2);
    bindAndFinish(0, 511, 'h3);
    bindAndFinish(0, 509, 'h4);
    checkOutput("fit_free5", 32'(free_space), 32'd5);
    applyStimulus(1, 8, 1'b1);
    applyStimulus(4, 3, 1'b1);
    stepCycles(1);
    checkOutput("fit_grant4", 32'(bus.grant), 32'h0010);
    checkOutput("fit_free2", 32'(free_space), 32'd2);
    applyStimulus(4, 3, 1'b0);
    setCell(4, 'h4444, 1'b1, 1'b1);
    stepCycles(1);
    setCell(4, 0, 1'b0, 1'b0);
    stepCycles(2);
    checkOutput("fit_p1_blocked", 32'(bus.busy), 32'd0);
    free_vld = 1'b1;
    stepCycles(6);
    free_vld = 1'b0;
    checkOutput("fit_free8", 32'(free_space), 32'd8);
    checkOutput("fit_still_idle", 32'(bus.busy), 32'd0);
    stepCycles(1);
    checkOutput("fit_grant1", 32'(bus.grant), 32'h0002);
    checkOutput("fit_free0", 32'(free_space), 32'd0);
    applyStimulus(1, 8, 1'b0);
    setCell(1, 'h1010, 1'b1, 1'b1);
    stepCycles(1);
    setCell(1, 0, 1'b0, 1'b0);
    stepCycles(1);

    // Grant and release together: 100 + 1 - 4
    free_vld = 1'b1;
    stepCycles(100);
    checkOutput("sim_free100", 32'(free_space), 32'd100);
    applyStimulus(6, 4, 1'b1);
    stepCycles(1);
    free_vld = 1'b0;
    applyStimulus(6, 4, 1'b0);
    checkOutput("sim_grant6", 32'(bus.grant), 32'h0040);
    checkOutput("sim_free97", 32'(free_space), 32'd97);
    setCell(6, 'h6666, 1'b1, 1'b1);
    stepCycles(1);
    setCell(6, 0, 1'b0, 1'b0);
    stepCycles(1);

    // Release at capacity saturates; zero-length request reserves one cell
    doReset();
    free_vld = 1'b1;
    stepCycles(1);
    free_vld = 1'b0;
    checkOutput("sat_free", 32'(free_space), 32'd2047);
    applyStimulus(8, 0, 1'b1);
    stepCycles(1);
    applyStimulus(8, 0, 1'b0);
    checkOutput("zlen_grant", 32'(bus.grant), 32'h0100);
    checkOutput("zlen_free", 32'(free_space), 32'd2046);
    setCell(8, 'h0808, 1'b1, 1'b1);
    stepCycles(1);
    setCell(8, 0, 1'b0, 1'b0);
    stepCycles(1);

    // Non-owner cells are ignored, then reset in the middle of a packet
    doReset();
    applyStimulus(0, 2, 1'b1);
    stepCycles(1);
    applyStimulus(0, 2, 1'b0);
    checkOutput("no_grant0", 32'(bus.grant), 32'h0001);
    setCell(7, 'hBEEF, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("no_p7_write", 32'(sram_wr_en), 32'd0);
    setCell(0, 'h1111, 1'b1, 1'b0);
    stepCycles(1);
    checkOutput("no_p0_write", 32'(sram_wr_en), 32'd1);
    checkOutput("no_p0_data", 32'(sram_wr_data), 32'h1111);
    checkOutput("no_free", 32'(free_space), 32'd2045);
    doReset();
    checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("mid_rst_grant", 32'(bus.grant), 32'd0);
    checkOutput("mid_rst_free", 32'(free_space), 32'd2047);
    checkOutput("mid_rst_wr_en", 32'(sram_wr_en), 32'd0);

`ifdef ARB_WATCHDOG_EN
    // Owner writes 2 of 6 cells then stalls; watchdog refunds 4
    begin
      logic seen;
      int   lat;
      seen = 1'b0;
      lat  = 0;
      applyStimulus(10, 6, 1'b1);
      stepCycles(1);
      applyStimulus(10, 6, 1'b0);
      checkOutput("wd_grant", 32'(bus.grant), 32'h0400);
      setCell(10, 'hAA00, 1'b1, 1'b0);
      stepCycles(1);
      setCell(10, 'hAA01, 1'b1, 1'b0);
      stepCycles(1);
      setCell(10, 0, 1'b0, 1'b0);
      applyStimulus(11, 1, 1'b1);
      checkOutput("wd_free_pre", 32'(free_space), 32'd2041);
      for (int c = 1; c <= 100 && !seen; c++) begin
        stepCycles(1);
        if (abort) begin
          seen = 1'b1;
          lat  = c;
        end
      end
      checkOutput("wd_abort_seen", 32'(seen), 32'd1);
      checkOutput("wd_latency", 32'(lat), 32'd63);
      checkOutput("wd_free_refund", 32'(free_space), 32'd2045);
      checkOutput("wd_busy_clear", 32'(bus.busy), 32'd0);
      stepCycles(1);
      checkOutput("wd_abort_pulse", 32'(abort), 32'd0);
      checkOutput("wd_next_grant", 32'(bus.grant), 32'h0800);
      applyStimulus(11, 1, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
